// File: rtl/uart_echo_checker.sv
// uart_echo_checker
//   Far-end initiator for the RS232 echo path. Sends a deterministic byte
//   sequence to an rs232_uart, one byte at a time (stop-and-wait). Each echo
//   is compared with the byte that was sent. The block then reports
//   pass/fail, an error count and an echo count.
//
//   Optional feature macro: ECHO_CHECKER_LFSR_EN
//     defined   -> the pattern is an 8-bit LFSR seeded from i_seed
//                  (a seed of 0x00 is replaced by 0x01)
//     undefined -> the pattern is seed + k (mod 256)
//
// Parameters
//   NUM_BYTES       bytes per run (1..65535)
//   TIMEOUT_CYCLES  cycles allowed in WAIT before the run aborts (>=2)
//
// Ports
//   i_clk               sole clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_start             start/restart a run (honoured in IDLE or DONE)
//   i_seed[7:0]         first pattern byte, captured on start
//   o_tx_data_out[7:0]  byte to the UART transmitter
//   o_write_tx_data     one-cycle write strobe to the UART
//   i_tx_buffer_full    UART TX FIFO full
//   i_rx_data_in[7:0]   head byte of the UART RX FIFO
//   i_rx_data_present   RX FIFO not empty
//   o_read_rx_data_ack  one-cycle pop strobe to the RX FIFO
//   o_busy              high in SEND/WAIT
//   o_done              high in DONE
//   o_pass              no mismatches and no timeout (valid with o_done)
//   o_timeout           run aborted on timeout (valid with o_done)
//   o_err_count[7:0]    mismatches plus timeout, saturating at 255
//   o_byte_count[15:0]  echoes received in the current or last run
module uart_echo_checker #(
  parameter int NUM_BYTES      = 256,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_seed,
  output logic [7:0]  o_tx_data_out,
  output logic        o_write_tx_data,
  input  logic        i_tx_buffer_full,
  input  logic [7:0]  i_rx_data_in,
  input  logic        i_rx_data_present,
  output logic        o_read_rx_data_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [7:0]  o_err_count,
  output logic [15:0] o_byte_count
);

  localparam int              TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   LP_TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     LP_NUM  = 16'(NUM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_pattern, w_pattern_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [7:0]    r_err, w_err_next, w_err_inc;
  logic [15:0]   r_bcnt, w_bcnt_next;
  logic          r_timeout, w_timeout_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic          r_wr, w_wr_next;
  logic          r_ack, w_ack_next;
  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;
  logic          r_pass, w_pass_next;

  function automatic logic [7:0] f_next_pattern(input logic [7:0] cur);
`ifdef ECHO_CHECKER_LFSR_EN
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
`else
    return cur + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] f_seed(input logic [7:0] s);
`ifdef ECHO_CHECKER_LFSR_EN
    // The all-zero state is the LFSR lock-up state.
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pattern <= 8'h00;
      r_timer   <= '0;
      r_err     <= 8'h00;
      r_bcnt    <= 16'h0000;
      r_timeout <= 1'b0;
      r_tx_data <= 8'h00;
      r_wr      <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pattern <= w_pattern_next;
      r_timer   <= w_timer_next;
      r_err     <= w_err_next;
      r_bcnt    <= w_bcnt_next;
      r_timeout <= w_timeout_next;
      r_tx_data <= w_tx_data_next;
      r_wr      <= w_wr_next;
      r_ack     <= w_ack_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_pass    <= w_pass_next;
    end
  end

  assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  always_comb begin
    w_state_next   = r_state;
    w_pattern_next = r_pattern;
    w_timer_next   = r_timer;
    w_err_next     = r_err;
    w_bcnt_next    = r_bcnt;
    w_timeout_next = r_timeout;
    w_tx_data_next = r_tx_data;
    w_wr_next      = 1'b0;
    w_ack_next     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        // Stray bytes are discarded. The UART drops rx_data_present one
        // cycle late, so never pop on two consecutive cycles.
        if (i_rx_data_present && !r_ack) begin
          w_ack_next = 1'b1;
        end
        if (i_start) begin
          w_state_next   = S_SEND;
          w_pattern_next = f_seed(i_seed);
          w_err_next     = 8'h00;
          w_bcnt_next    = 16'h0000;
          w_timeout_next = 1'b0;
        end
      end
      S_SEND: begin
        // Back-pressure stalls here without running the timer.
        if (!i_tx_buffer_full) begin
          w_wr_next      = 1'b1;
          w_tx_data_next = r_pattern;
          w_timer_next   = '0;
          w_state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Data takes priority over a timeout in the same cycle.
        if (i_rx_data_present) begin
          w_ack_next     = 1'b1;
          w_pattern_next = f_next_pattern(r_pattern);
          w_bcnt_next    = r_bcnt + 16'd1;
          if (i_rx_data_in != r_pattern) begin
            w_err_next = w_err_inc;
          end
          w_state_next = (r_bcnt + 16'd1 == LP_NUM) ? S_DONE : S_SEND;
        end else if (r_timer == LP_TMAX) begin
          w_timeout_next = 1'b1;
          w_err_next     = w_err_inc;
          w_state_next   = S_DONE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Status outputs are registered from the next-state values.
    w_busy_next = (w_state_next == S_SEND) || (w_state_next == S_WAIT);
    w_done_next = (w_state_next == S_DONE);
    w_pass_next = w_done_next && (w_err_next == 8'h00) && !w_timeout_next;
  end

  assign o_tx_data_out      = r_tx_data;
  assign o_write_tx_data    = r_wr;
  assign o_read_rx_data_ack = r_ack;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_timeout          = r_timeout;
  assign o_err_count        = r_err;
  assign o_byte_count       = r_bcnt;

endmodule

// File: tb/tb_uart_echo_checker.sv
module tb_uart_echo_checker;

  localparam int NB = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [7:0]  seed_in = 8'h00;
  logic        tx_full = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_present = 1'b0;
  logic [7:0]  o_tx_data_out;
  logic        o_write_tx_data;
  logic        o_read_rx_data_ack;
  logic        o_busy, o_done, o_pass, o_timeout;
  logic [7:0]  o_err_count;
  logic [15:0] o_byte_count;

  uart_echo_checker #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_in), .i_seed(seed_in),
    .o_tx_data_out(o_tx_data_out), .o_write_tx_data(o_write_tx_data),
    .i_tx_buffer_full(tx_full), .i_rx_data_in(rx_data),
    .i_rx_data_present(rx_present), .o_read_rx_data_ack(o_read_rx_data_ack),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_err_count(o_err_count), .o_byte_count(o_byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // UART + echo link model state
  logic [7:0] sent_q[$];
  logic [7:0] rx_fifo[$];
  logic [7:0] pend_b[$];
  int         pend_t[$];
  int cyc = 0, last_wr_cyc = 0, wr_cnt = 0, ack_cnt = 0, overlap_cnt = 0;
  int drop_idx = -1, corrupt_idx = -1, fixed_delay = 10, model_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pattern: byte k of a run started with seed s.
  function automatic logic [7:0] pat_at(input logic [7:0] s, input int k);
    logic [7:0] v;
`ifdef ECHO_CHECKER_LFSR_EN
    v = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
    v = s + 8'(k);
`endif
    return v;
  endfunction

  // Echo link: every written byte comes back after a delay, unless dropped.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (o_write_tx_data) begin
        if (o_read_rx_data_ack) overlap_cnt++;
        sent_q.push_back(o_tx_data_out);
        last_wr_cyc = cyc;
        wr_cnt++;
        model_idx = sent_q.size() - 1;
        if (model_idx != drop_idx) begin
          pend_b.push_back(o_tx_data_out ^ ((model_idx == corrupt_idx) ? 8'h01 : 8'h00));
          pend_t.push_back(cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 15))));
        end
      end
      if (o_read_rx_data_ack) begin
        ack_cnt++;
        if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
      end
      if (pend_b.size() > 0 && pend_t[0] <= cyc) begin
        rx_fifo.push_back(pend_b.pop_front());
        void'(pend_t.pop_front());
      end
      rx_present = (rx_fifo.size() != 0);
      rx_data    = (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_pass"},  32'(o_pass), 0);
    check({tag, "_tmo"},   32'(o_timeout), 0);
    check({tag, "_wr"},    32'(o_write_tx_data), 0);
    check({tag, "_ack"},   32'(o_read_rx_data_ack), 0);
    check({tag, "_err"},   32'(o_err_count), 0);
    check({tag, "_bcnt"},  32'(o_byte_count), 0);
    check({tag, "_txd"},   32'(o_tx_data_out), 0);
  endtask

  task automatic run_and_check(input logic [7:0] seed, input int corrupt, input int drop,
                               input int bp, input int delay);
    int exp_sent, exp_bcnt, exp_err, wr0, ack0, waited;
    logic exp_to;
    sent_q.delete();
    drop_idx = drop; corrupt_idx = corrupt; fixed_delay = delay;
    wr0 = wr_cnt; ack0 = ack_cnt;
    tx_full = (bp > 0);
    @(negedge clk); seed_in = seed; start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    check("busy_after_start", 32'(o_busy), 1);
    if (bp > 0) begin
      repeat (bp) @(negedge clk);
      check("bp_no_write", 32'(wr_cnt - wr0), 0);
      check("bp_no_timeout", 32'(o_timeout), 0);
      check("bp_still_busy", 32'(o_busy), 1);
      tx_full = 1'b0;
    end else begin
      @(negedge clk);
      check("write_at_N1", 32'(o_write_tx_data), 1);
    end
    waited = 0;
    while (!o_done && waited < 2000) begin
      @(negedge clk); waited++;
    end
    check("done_reached", 32'(o_done), 1);
    if (drop >= 0) begin
      check("timeout_latency", 32'(cyc - last_wr_cyc), 32'(TO));
      exp_sent = drop + 1; exp_bcnt = drop; exp_to = 1'b1;
      exp_err  = ((corrupt >= 0 && corrupt < drop) ? 1 : 0) + 1;
      repeat (30) @(negedge clk);
    end else begin
      exp_sent = NB; exp_bcnt = NB; exp_to = 1'b0;
      exp_err  = (corrupt >= 0) ? 1 : 0;
    end
    check("writes", 32'(wr_cnt - wr0), 32'(exp_sent));
    for (int k = 0; k < sent_q.size() && k < exp_sent; k++)
      check($sformatf("sent_byte%0d", k), 32'(sent_q[k]), 32'(pat_at(seed, k)));
    check("done_hold", 32'(o_done), 1);
    check("pass", 32'(o_pass), 32'((exp_err == 0) && !exp_to));
    check("timeout", 32'(o_timeout), 32'(exp_to));
    check("err_count", 32'(o_err_count), 32'(exp_err));
    check("byte_count", 32'(o_byte_count), 32'(exp_bcnt));
    check("acks", 32'(ack_cnt - ack0), 32'(exp_bcnt));
    check("no_wr_ack_overlap", 32'(overlap_cnt), 0);
    $display("run seed=%02h corrupt=%0d drop=%0d bp=%0d -> err=%0d bcnt=%0d pass=%0b tmo=%0b",
             seed, corrupt, drop, bp, o_err_count, o_byte_count, o_pass, o_timeout);
  endtask

  task automatic stray_check(input string tag);
    int ack0;
    logic [7:0] e0;
    logic [15:0] b0;
    logic p0;
    ack0 = ack_cnt; e0 = o_err_count; b0 = o_byte_count; p0 = o_pass;
    rx_fifo.push_back(8'hA5);
    repeat (6) @(negedge clk);
    check({tag, "_ack_once"}, 32'(ack_cnt - ack0), 1);
    check({tag, "_fifo_empty"}, 32'(rx_fifo.size()), 0);
    check({tag, "_err"}, 32'(o_err_count), 32'(e0));
    check({tag, "_bcnt"}, 32'(o_byte_count), 32'(b0));
    check({tag, "_pass"}, 32'(o_pass), 32'(p0));
    check({tag, "_busy"}, 32'(o_busy), 0);
    $display("stray %s: acks=%0d", tag, ack_cnt - ack0);
  endtask

  initial begin
    int c;
    // Reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_done", 32'(o_done), 0);

    // Stray byte in IDLE, then a normal run
    stray_check("idle");

    // Ideal echo, seed FE: FE FF 00 01 (incrementing build)
    run_and_check(8'hFE, -1, -1, 0, 10);
    // Corrupted echo of byte 2
    run_and_check(8'hFE, 2, -1, 0, 10);
    // Stray byte in DONE must not disturb the result
    stray_check("done");
    // Timeout: byte 1 dropped
    run_and_check(8'h10, -1, 1, 0, 10);
    // Back-pressure for 100 cycles
    run_and_check(8'h33, -1, -1, 100, 10);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      c = int'($urandom_range(0, 4)) - 1;
      run_and_check(8'($urandom), c, -1, 0, 0);
    end

    // Reset mid-run while in WAIT
    sent_q.delete(); drop_idx = 0; corrupt_idx = -1; fixed_delay = 10;
    @(negedge clk); seed_in = 8'h5A; start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    rx_fifo.delete(); pend_b.delete(); pend_t.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Seed 0 after reset
    run_and_check(8'h00, -1, -1, 0, 0);
`ifdef ECHO_CHECKER_LFSR_EN
    begin
      logic [7:0] lf [4];
      lf[0] = 8'h01; lf[1] = 8'h02; lf[2] = 8'h04; lf[3] = 8'h08;
      for (int k = 0; k < 4 && k < sent_q.size(); k++)
        check($sformatf("lfsr_byte%0d", k), 32'(sent_q[k]), 32'(lf[k]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
